afifo_wr_arbiter: RTL and testbench
===================================

Name: afifo_wr_arbiter

Overview:
- Write-side scheduler for the async FIFO.
- Shares the single FIFO write port (winc/wdata, gated by wfull) between NUM_REQ requesters.
- Uses round-robin arbitration with burst locking and a per-grant beat limit.
- Sits entirely in the write clock domain, between requester blocks and the FIFO write interface.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 8: FIFO data width.
- BURST_MAX, 4: max beats per grant before forced rotation (1..16).

Ports:
- wclk  in  1  write-domain clock
- wrst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  final beat of burst
- req_ready  out  NUM_REQ  beat accepted this cycle (one-hot or zero)
- wfull  in  1  FIFO full flag (write domain)
- winc  out  1  FIFO write enable
- wdata  out  DATA_WIDTH  FIFO write data
- grant_id  out  $clog2(NUM_REQ)  current owner; valid when busy=1
- busy  out  1  high in GRANT state

Behaviour:
- Clock and reset: one clock (wclk); reset wrst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, busy=0, grant_id=0, beat_cnt=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - winc=0, req_ready=0.
- IDLE:
  - If any req_valid is set, pick the first set bit searching upward from rr_ptr+1 (mod NUM_REQ).
  - Register the pick into grant_id, set beat_cnt=0, move to GRANT next cycle.
  - No transfers in IDLE, so arbitration latency is 1 cycle.
- GRANT, with g = grant_id:
  - Transfer when req_valid[g] && !wfull.
  - On transfer: winc=1, req_ready[g]=1, wdata=req_data[g], beat_cnt++.
  - winc, req_ready and wdata are combinational from registered state; no request-to-winc path exists outside GRANT.
- GRANT -> IDLE, when any of these hold:
  - a transfer occurs with req_last[g]=1;
  - a transfer occurs with beat_cnt==BURST_MAX-1;
  - req_valid[g]==0 (requester abandoned the grant).
- On every GRANT -> IDLE exit, rr_ptr<=g.
- wfull=1 in GRANT: stall. winc=0, req_ready=0; beat_cnt and grant held; grant never released because of full.
- Never assert winc while wfull=1, including on the cycle wfull rises.
- Simultaneous last beat and BURST_MAX: a single exit; no double count.
- NUM_REQ=1: rotation is trivial; same FSM applies.
- Reset mid-burst: immediate return to reset values. A beat presented in that cycle is not accepted.
- Width rules:
  - beat_cnt width is $clog2(BURST_MAX+1).
  - rr_ptr increment wraps modulo NUM_REQ; non-power-of-2 is legal.
- Requester contract: req_data[g] and req_last[g] held stable while req_valid[g]=1 and req_ready[g]=0.

Optional Feature:
- Macro: AFIFO_WR_ARB_STATS_EN.
- Defined: adds these output ports:
  - stat_beats (NUM_REQ*16): per-requester accepted-beat counters, saturating at 16'hFFFF;
  - stat_full_stall (16): cycles in GRANT with req_valid[g]=1 and wfull=1, saturating.
  - All counters reset to 0 on wrst_n and are not otherwise clearable.
- Undefined: no such ports or logic exist; behaviour is otherwise identical.

Decomposition:
- Package afifo_wr_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
  - localparam STAT_W=16;
  - function rr_next(): reference pick model, shared with the bench.
- Sub-module rr_priority_picker: combinational. Inputs req vector and rr_ptr; outputs pick index and any_req. Instantiated once in IDLE decode.

Test Plan:
- Single requester burst: req 0 sends 3 beats, last on beat 3, wfull=0 -> grant after 1 idle cycle; winc high 3 consecutive cycles; wdata 0x11,0x22,0x33; busy falls the cycle after the last beat.
- Round-robin fairness: all 4 requesters continuously valid, 1-beat bursts -> grant order 0,1,2,3,0,1 with one IDLE cycle between grants.
- BURST_MAX cut: req 2 streams 10 beats with no req_last, BURST_MAX=4 -> exactly 4 beats, release, then reacquire only after other pending requesters are served.
- Full stall: wfull asserted for 5 cycles mid-burst after beat 2 -> winc=0 and req_ready=0 for all 5 cycles; grant_id unchanged; beat 3 written on the first cycle wfull=0; no beat lost or duplicated, checked by a scoreboard against FIFO contents.
- Abandon and reset: req 1 drops valid mid-burst -> IDLE next cycle, rr_ptr=1. Then wrst_n pulsed low during another grant -> winc=0 immediately, grant_id=0; first post-reset grant goes to requester 0 when all are requesting.
- Stats (AFIFO_WR_ARB_STATS_EN): 70000 beats from req 3 -> stat_beats[3]=16'hFFFF; 5-cycle full stall -> stat_full_stall=5.

Source files
------------

// File: rtl/afifo_wr_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-side arbiter.
// Also carries the reference round-robin pick function used outside the RTL datapath.
package afifo_wr_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam int STAT_W = 16;

  // Reference pick: first set request searching upward from ptr+1, wrapping modulo n.
  function automatic int unsigned rr_next(input logic [7:0] req, input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    rr_next = ptr;
    for (int k = int'(n); k >= 1; k--) begin
      idx = (ptr + int'(k)) % n;
      if (req[idx]) begin
        rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/afifo_wr_arbiter_picker.sv
// Combinational round-robin picker: lowest requester above rr_ptr, else lowest overall.
module rr_priority_picker
  import afifo_wr_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] pick,
  output logic          any_req
);

  logic [N-1:0] mask_s;
  logic [N-1:0] masked_s;
  logic [N-1:0] src_s;

  // Mask off requesters at or below the pointer, fall back to the full vector when empty
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < N; i++) begin
      mask_s[i] = (IW'(i) > rr_ptr);
    end
    masked_s = req & mask_s;
    src_s    = (|masked_s) ? masked_s : req;
    pick     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (src_s[i]) begin
        pick = IW'(i);
      end else begin
        pick = pick;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin, burst-locking scheduler for the async FIFO write port (write clock domain).
// Optional per-requester statistics are enabled with the AFIFO_WR_ARB_STATS_EN macro.
module afifo_wr_arbiter
  import afifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4,
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = $clog2(BURST_MAX + 1)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
`ifdef AFIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]     stat_beats,
  output logic [STAT_W-1:0]             stat_full_stall
`endif
);

  arb_state_e            state_r;
  logic [ID_W-1:0]       grant_id_r;
  logic [ID_W-1:0]       rr_ptr_r;
  logic [CNT_W-1:0]      beat_cnt_r;
  logic [ID_W-1:0]       pick_s;
  logic                  any_req_s;
  logic                  in_grant_s;
  logic                  g_valid_s;
  logic                  g_last_s;
  logic [DATA_WIDTH-1:0] g_data_s;
  logic                  xfer_s;
  logic                  exit_s;

  rr_priority_picker #(.N(NUM_REQ)) u_picker (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_r),
    .pick    (pick_s),
    .any_req (any_req_s)
  );

  // Select the current owner's beat and decide transfer / release for this cycle
  always_comb begin
    g_valid_s = 1'b0;
    g_last_s  = 1'b0;
    g_data_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      g_valid_s = g_valid_s | ((grant_id_r == ID_W'(i)) & req_valid[i]);
      g_last_s  = g_last_s  | ((grant_id_r == ID_W'(i)) & req_last[i]);
      g_data_s  = g_data_s  | ((grant_id_r == ID_W'(i)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH]
                                                         : {DATA_WIDTH{1'b0}});
    end
    in_grant_s = (state_r == ARB_GRANT);
    // wfull gates the transfer combinationally so winc never overlaps a full cycle
    xfer_s = in_grant_s & g_valid_s & ~wfull;
    exit_s = in_grant_s & (~g_valid_s |
             (xfer_s & (g_last_s | (beat_cnt_r == CNT_W'(BURST_MAX - 1)))));
  end

  // Write-port drive: only the owner can be acknowledged, and only on a transfer
  always_comb begin
    winc  = xfer_s;
    wdata = xfer_s ? g_data_s : {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer_s & (grant_id_r == ID_W'(i));
    end
  end

  assign grant_id = grant_id_r;
  assign busy     = in_grant_s;

  // Arbitration FSM: pick in IDLE, stream beats in GRANT, rotate pointer on release
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r    <= ARB_IDLE;
      grant_id_r <= '0;
      beat_cnt_r <= '0;
      rr_ptr_r   <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (any_req_s) begin
            grant_id_r <= pick_s;
            beat_cnt_r <= '0;
            state_r    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (xfer_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
          end
          if (exit_s) begin
            rr_ptr_r <= grant_id_r;
            state_r  <= ARB_IDLE;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef AFIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] stat_beats_r [NUM_REQ];
  logic [STAT_W-1:0] stat_full_stall_r;

  // Saturating usage counters, cleared only by the hardware reset
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_beats_r[i] <= '0;
      end
      stat_full_stall_r <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer_s && (grant_id_r == ID_W'(i)) && (stat_beats_r[i] != {STAT_W{1'b1}})) begin
          stat_beats_r[i] <= stat_beats_r[i] + STAT_W'(1);
        end
      end
      if (in_grant_s && g_valid_s && wfull && (stat_full_stall_r != {STAT_W{1'b1}})) begin
        stat_full_stall_r <= stat_full_stall_r + STAT_W'(1);
      end
    end
  end

  // Flatten the per-requester counters onto the packed port
  always_comb begin
    stat_beats = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_beats[i*STAT_W +: STAT_W] = stat_beats_r[i];
    end
  end

  assign stat_full_stall = stat_full_stall_r;
`else
`endif

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Randomized bench for afifo_wr_arbiter against a cycle-level reference model of the arbitration rules.
module tb_afifo_wr_arbiter;
  import afifo_wr_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int IW = 2;

  logic            wclk = 1'b0;
  logic            wrst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            wfull;
  logic            winc;
  logic [DW-1:0]   wdata;
  logic [IW-1:0]   grant_id;
  logic            busy;
`ifdef AFIFO_WR_ARB_STATS_EN
  logic [N*16-1:0] stat_beats;
  logic [15:0]     stat_full_stall;
`endif

  always #5 wclk = ~wclk;

  afifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef AFIFO_WR_ARB_STATS_EN
    ,
    .stat_beats      (stat_beats),
    .stat_full_stall (stat_full_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Requester drivers
  bit          dv [N];
  logic [DW-1:0] dd [N];
  bit          dl [N];
  int          mode;
  int          dir_idx;

  // Reference model: owner=-1 means no grant; served counts beats in the current grant
  int owner = -1;
  int served = 0;
  int ptr = N - 1;
  int model_writes = 0;
  int dut_writes = 0;
  int exp_stall = 0;
  int exp_beats [N];

  task automatic new_beat(input int i);
    case (mode)
      0: begin
        if (i == 0 && dir_idx < 3) begin
          dv[i] = 1'b1;
          dd[i] = DW'(17 * (dir_idx + 1));
          dl[i] = (dir_idx == 2);
          dir_idx++;
        end else begin
          dv[i] = 1'b0;
        end
      end
      1: begin
        dv[i] = 1'b1; dd[i] = DW'($urandom); dl[i] = 1'b1;
      end
      2: begin
        dv[i] = ($urandom_range(0, 99) < 60); dd[i] = DW'($urandom); dl[i] = ($urandom_range(0, 3) == 0);
      end
      default: begin
        dv[i] = ($urandom_range(0, 99) < 90); dd[i] = DW'($urandom); dl[i] = 1'b0;
      end
    endcase
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = dv[i];
      req_last[i]  = dl[i];
      req_data[i*DW +: DW] = dd[i];
    end
  endtask

  task automatic step();
    logic [N-1:0] rdy;
    logic [7:0]   vec;
    bit           ew;
    @(negedge wclk);
    drive();
    case (mode)
      2:       wfull = ($urandom_range(0, 4) == 0);
      3:       wfull = ($urandom_range(0, 2) == 0);
      default: wfull = 1'b0;
    endcase
    #1;
    rdy = '0;
    ew  = 1'b0;
    check("busy", busy, owner >= 0);
    if (owner >= 0) begin
      check("grant_id", grant_id, owner);
      if (dv[owner] && !wfull) begin
        ew = 1'b1;
        rdy[owner] = 1'b1;
        check("wdata", wdata, dd[owner]);
        served++;
        model_writes++;
        exp_beats[owner]++;
      end else if (dv[owner]) begin
        exp_stall++;
      end
      if (!dv[owner] || (ew && (dl[owner] || served == BM))) begin
        ptr = owner;
        owner = -1;
      end
    end else begin
      vec = '0;
      for (int i = 0; i < N; i++) vec[i] = dv[i];
      if (vec != 8'h00) begin
        owner = int'(rr_next(vec, ptr, N));
        served = 0;
      end
    end
    check("winc", winc, ew);
    check("req_ready", req_ready, rdy);
    if (winc) dut_writes++;
    for (int i = 0; i < N; i++) begin
      if (rdy[i] || !dv[i]) new_beat(i);
      else if (mode >= 2 && $urandom_range(0, 19) == 0) dv[i] = 1'b0;
    end
  endtask

  task automatic reset_mid();
    int k = 0;
    while (owner < 0 && k < 200) begin
      step();
      k++;
    end
    @(negedge wclk);
    drive();
    wfull = 1'b0;
    #1;
    check("pre_reset_busy", busy, 1'b1);
    wrst_n = 1'b0;
    #1;
    check("rst_mid_winc", winc, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_grant", grant_id, 0);
    check("rst_mid_ready", req_ready, 0);
    owner = -1; served = 0; ptr = N - 1; exp_stall = 0;
    for (int i = 0; i < N; i++) exp_beats[i] = 0;
    mode = 1;
    for (int i = 0; i < N; i++) new_beat(i);
    @(negedge wclk);
    req_valid = '0;
    wrst_n = 1'b1;
  endtask

  task automatic run(input int m, input int cycles);
    mode = m;
    for (int c = 0; c < cycles; c++) step();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      dv[i] = 1'b0; dd[i] = '0; dl[i] = 1'b0; exp_beats[i] = 0;
    end
    wrst_n    = 1'b0;
    req_valid = '1;
    req_last  = '0;
    req_data  = '0;
    wfull     = 1'b0;
    #23;
    check("rst_busy", busy, 1'b0);
    check("rst_winc", winc, 1'b0);
    check("rst_grant", grant_id, 0);
    check("rst_ready", req_ready, 0);
    @(negedge wclk);
    req_valid = '0;
    wrst_n = 1'b1;

    mode = 0;
    dir_idx = 0;
    for (int i = 0; i < N; i++) new_beat(i);
    run(0, 12);
    check("dir_burst_writes", dut_writes, 3);
    run(1, 40);
    run(2, 1500);
    reset_mid();
    run(1, 20);
    run(3, 600);
    run(2, 600);
    check("total_writes", dut_writes, model_writes);
`ifdef AFIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("stat_beats", stat_beats[i*16 +: 16], exp_beats[i]);
    check("stat_full_stall", stat_full_stall, exp_stall);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
